// File: rtl/pipeline_decode_stage.sv
// Decode stage: register file, immediate generator and a registered ID/EX boundary
// with valid/ready handshake, flush, WB-to-ID bypass and load-use stall detection.
module pipeline_decode_stage #(
  parameter int unsigned XLEN      = 32,
  parameter int unsigned NREGS     = 32,
  parameter bit          BYPASS_EN = 1'b1
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            if_valid_i,
  output logic            id_ready_o,
  input  logic [31:0]     instruction_i,
  input  logic [XLEN-1:0] pc_i,
  input  logic            wb_we_i,
  input  logic [4:0]      wb_addr_i,
  input  logic [XLEN-1:0] wb_data_i,
  input  logic            ex_ready_i,
  input  logic [4:0]      ex_rd_i,
  input  logic            ex_mem_read_i,
  input  logic            flush_i,
  output logic            id_valid_o,
  output logic            hazard_stall_o,
  output logic [31:0]     instruction_o,
  output logic [XLEN-1:0] pc_o,
  output logic [6:0]      opcode_o,
  output logic [2:0]      funct3_o,
  output logic [6:0]      funct7_o,
  output logic [4:0]      rs1_o,
  output logic [4:0]      rs2_o,
  output logic [4:0]      rd_o,
  output logic [XLEN-1:0] rs1_data_o,
  output logic [XLEN-1:0] rs2_data_o,
  output logic [XLEN-1:0] imm_o
);

  localparam int unsigned AW      = $clog2(NREGS);
  localparam logic [5:0]  NRegsW  = 6'(NREGS);

  logic [XLEN-1:0] rf_q [NREGS];

  logic [4:0]      rs1_addr, rs2_addr;
  logic [XLEN-1:0] rs1_data, rs2_data;
  logic [31:0]     imm32;
  logic [XLEN-1:0] imm_ext;
  logic            wb_write;
  logic            capture, load;
  logic            valid_d, valid_q;
  logic [31:0]     instr_q;
  logic [XLEN-1:0] pc_q, rs1_data_q, rs2_data_q, imm_q;

  assign rs1_addr = instruction_i[19:15];
  assign rs2_addr = instruction_i[24:20];
  assign wb_write = wb_we_i && (wb_addr_i != 5'd0) && ({1'b0, wb_addr_i} < NRegsW);

  // Out-of-range addresses read as zero; write-first forwarding only for real registers.
  function automatic logic [XLEN-1:0] rf_read(input logic [4:0] addr);
    logic [XLEN-1:0] val;
    val = '0;
    if (addr != 5'd0 && {1'b0, addr} < NRegsW) begin
      if (BYPASS_EN && wb_write && wb_addr_i == addr) val = wb_data_i;
      else                                              val = rf_q[addr[AW-1:0]];
    end
    return val;
  endfunction

  always_comb begin
    rs1_data = rf_read(rs1_addr);
    rs2_data = rf_read(rs2_addr);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned i = 0; i < NREGS; i++) rf_q[i] <= '0;
    end else if (wb_write) begin
      rf_q[wb_addr_i[AW-1:0]] <= wb_data_i;
    end
  end

  always_comb begin
    imm32 = {{20{instruction_i[31]}}, instruction_i[31:20]};
    case (instruction_i[6:0])
      7'b0100011: imm32 = {{20{instruction_i[31]}}, instruction_i[31:25], instruction_i[11:7]};
      7'b1100011: imm32 = {{19{instruction_i[31]}}, instruction_i[31], instruction_i[7],
                           instruction_i[30:25], instruction_i[11:8], 1'b0};
      7'b0110111,
      7'b0010111: imm32 = {instruction_i[31:12], 12'b0};
      7'b1101111: imm32 = {{11{instruction_i[31]}}, instruction_i[31], instruction_i[19:12],
                           instruction_i[20], instruction_i[30:21], 1'b0};
      default:    imm32 = {{20{instruction_i[31]}}, instruction_i[31:20]};
    endcase
  end

  assign imm_ext = XLEN'($signed(imm32));

  assign hazard_stall_o = if_valid_i & ex_mem_read_i & (ex_rd_i != 5'd0) &
                          ((ex_rd_i == rs1_addr) | (ex_rd_i == rs2_addr));
  assign id_ready_o     = (!valid_q | ex_ready_i) & !hazard_stall_o;
  assign capture        = if_valid_i & id_ready_o;
  assign load           = capture & !flush_i;

  // Flush beats capture; an idle consumed slot becomes a bubble.
  always_comb begin
    valid_d = valid_q;
    if (flush_i)         valid_d = 1'b0;
    else if (capture)    valid_d = 1'b1;
    else if (ex_ready_i) valid_d = 1'b0;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q    <= 1'b0;
      instr_q    <= '0;
      pc_q       <= '0;
      rs1_data_q <= '0;
      rs2_data_q <= '0;
      imm_q      <= '0;
    end else begin
      valid_q <= valid_d;
      if (load) begin
        instr_q    <= instruction_i;
        pc_q       <= pc_i;
        rs1_data_q <= rs1_data;
        rs2_data_q <= rs2_data;
        imm_q      <= imm_ext;
      end
    end
  end

  assign id_valid_o    = valid_q;
  assign instruction_o = instr_q;
  assign pc_o          = pc_q;
  assign opcode_o      = instr_q[6:0];
  assign funct3_o      = instr_q[14:12];
  assign funct7_o      = instr_q[31:25];
  assign rs1_o         = instr_q[19:15];
  assign rs2_o         = instr_q[24:20];
  assign rd_o          = instr_q[11:7];
  assign rs1_data_o    = rs1_data_q;
  assign rs2_data_o    = rs2_data_q;
  assign imm_o         = imm_q;

endmodule

// File: tb/tb_pipeline_decode_stage.sv
// Scoreboard bench for pipeline_decode_stage: one instance with bypass, one without,
// driven by the same directed instruction stream.
module tb_pipeline_decode_stage;

  typedef struct packed {
    logic [31:0] ins;
    logic [31:0] pc;
    logic [31:0] rs1d;
    logic [31:0] rs2d;
    logic [31:0] imm;
  } exp_t;

  logic        clk, rst_n;
  logic        if_valid, wb_we, ex_ready, ex_mem_read, flush;
  logic [31:0] instruction, pc, wb_data;
  logic [4:0]  wb_addr, ex_rd;

  logic        id_ready0, id_valid0, hazard0;
  logic [31:0] instr_o0, pc_o0, rs1d0, rs2d0, imm0;
  logic [6:0]  opc0, f7_0;
  logic [2:0]  f3_0;
  logic [4:0]  rs1_0, rs2_0, rd0;

  logic        id_ready1, id_valid1, hazard1;
  logic [31:0] instr_o1, pc_o1, rs1d1, rs2d1, imm1;
  logic [6:0]  opc1, f7_1;
  logic [2:0]  f3_1;
  logic [4:0]  rs1_1, rs2_1, rd1;

  exp_t q0[$];
  exp_t q1[$];
  int   n_cmp = 0;
  int   n_err = 0;

  pipeline_decode_stage #(.XLEN(32), .NREGS(32), .BYPASS_EN(1'b1)) dut0 (
    .clk_i(clk), .rst_ni(rst_n), .if_valid_i(if_valid), .id_ready_o(id_ready0),
    .instruction_i(instruction), .pc_i(pc), .wb_we_i(wb_we), .wb_addr_i(wb_addr),
    .wb_data_i(wb_data), .ex_ready_i(ex_ready), .ex_rd_i(ex_rd), .ex_mem_read_i(ex_mem_read),
    .flush_i(flush), .id_valid_o(id_valid0), .hazard_stall_o(hazard0),
    .instruction_o(instr_o0), .pc_o(pc_o0), .opcode_o(opc0), .funct3_o(f3_0),
    .funct7_o(f7_0), .rs1_o(rs1_0), .rs2_o(rs2_0), .rd_o(rd0), .rs1_data_o(rs1d0),
    .rs2_data_o(rs2d0), .imm_o(imm0)
  );

  pipeline_decode_stage #(.XLEN(32), .NREGS(32), .BYPASS_EN(1'b0)) dut1 (
    .clk_i(clk), .rst_ni(rst_n), .if_valid_i(if_valid), .id_ready_o(id_ready1),
    .instruction_i(instruction), .pc_i(pc), .wb_we_i(wb_we), .wb_addr_i(wb_addr),
    .wb_data_i(wb_data), .ex_ready_i(ex_ready), .ex_rd_i(ex_rd), .ex_mem_read_i(ex_mem_read),
    .flush_i(flush), .id_valid_o(id_valid1), .hazard_stall_o(hazard1),
    .instruction_o(instr_o1), .pc_o(pc_o1), .opcode_o(opc1), .funct3_o(f3_1),
    .funct7_o(f7_1), .rs1_o(rs1_1), .rs2_o(rs2_1), .rd_o(rd1), .rs1_data_o(rs1d1),
    .rs2_data_o(rs2d1), .imm_o(imm1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_tx(input string tag, input exp_t e, input logic [31:0] ins,
                          input logic [31:0] pcv, input logic [31:0] r1, input logic [31:0] r2,
                          input logic [31:0] imm, input logic [4:0] rd, input logic [4:0] a1,
                          input logic [4:0] a2, input logic [6:0] opc, input logic [6:0] f7,
                          input logic [2:0] f3);
    chk({tag, ".instruction"}, ins, e.ins);
    chk({tag, ".pc"}, pcv, e.pc);
    chk({tag, ".rs1_data"}, r1, e.rs1d);
    chk({tag, ".rs2_data"}, r2, e.rs2d);
    chk({tag, ".imm"}, imm, e.imm);
    chk({tag, ".rd"}, {27'd0, rd}, {27'd0, e.ins[11:7]});
    chk({tag, ".fields"}, {a1, a2, opc, f7, f3, 3'd0},
        {e.ins[19:15], e.ins[24:20], e.ins[6:0], e.ins[31:25], e.ins[14:12], 3'd0});
  endtask

  // Drive one instruction for one cycle and record what each instance must present.
  task automatic send(input logic [31:0] ins, input logic [31:0] pcv, input logic [31:0] r1a,
                      input logic [31:0] r2a, input logic [31:0] r1b, input logic [31:0] r2b,
                      input logic [31:0] imm);
    if_valid    = 1'b1;
    instruction = ins;
    pc          = pcv;
    q0.push_back('{ins: ins, pc: pcv, rs1d: r1a, rs2d: r2a, imm: imm});
    q1.push_back('{ins: ins, pc: pcv, rs1d: r1b, rs2d: r2b, imm: imm});
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    rst_n = 1'b0; if_valid = 1'b0; wb_we = 1'b0; ex_ready = 1'b1; ex_mem_read = 1'b0;
    flush = 1'b0; instruction = '0; pc = '0; wb_data = '0; wb_addr = '0; ex_rd = '0;

    // Transfer monitor: EX takes the ID/EX contents when valid, ready and not flushed.
    fork
      forever begin
        @(negedge clk);
        if (rst_n && ex_ready && !flush) begin
          if (id_valid0) begin
            if (q0.size() == 0) chk("dut0.unexpected_valid", 32'd1, 32'd0);
            else begin
              e = q0.pop_front();
              check_tx("dut0", e, instr_o0, pc_o0, rs1d0, rs2d0, imm0, rd0, rs1_0, rs2_0,
                       opc0, f7_0, f3_0);
            end
          end
          if (id_valid1) begin
            if (q1.size() == 0) chk("dut1.unexpected_valid", 32'd1, 32'd0);
            else begin
              e = q1.pop_front();
              check_tx("dut1", e, instr_o1, pc_o1, rs1d1, rs2d1, imm1, rd1, rs1_1, rs2_1,
                       opc1, f7_1, f3_1);
            end
          end
        end
      end
    join_none

    repeat (2) @(negedge clk);
    chk("reset.id_valid", {31'd0, id_valid0}, 32'd0);
    chk("reset.id_ready", {31'd0, id_ready0}, 32'd1);
    chk("reset.instruction", instr_o0, 32'd0);
    chk("reset.rs1_data", rs1d0, 32'd0);
    chk("reset.imm", imm0, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // x5 = 0x1234, then addi x6,x5,-1
    wb_we = 1'b1; wb_addr = 5'd5; wb_data = 32'h1234;
    tick();
    wb_we = 1'b0;
    send(32'hFFF28313, 32'h100, 32'h1234, 32'h0, 32'h1234, 32'h0, 32'hFFFFFFFF);

    // add x8,x7,x0 captured alongside a WB write of x7
    wb_we = 1'b1; wb_addr = 5'd7; wb_data = 32'hDEAD;
    send(32'h00038433, 32'h104, 32'hDEAD, 32'h0, 32'h0, 32'h0, 32'h0);
    wb_we = 1'b0;
    send(32'h00038433, 32'h108, 32'hDEAD, 32'h0, 32'hDEAD, 32'h0, 32'h0);

    // Load-use hazard on rs2=x7
    if_valid = 1'b1; instruction = 32'h007004B3; pc = 32'h10C;
    ex_mem_read = 1'b1; ex_rd = 5'd7;
    @(negedge clk);
    chk("hazard.stall", {31'd0, hazard0}, 32'd1);
    chk("hazard.id_ready", {31'd0, id_ready0}, 32'd0);
    tick();
    @(negedge clk);
    chk("hazard.bubble", {31'd0, id_valid0}, 32'd0);
    @(posedge clk); #1;
    ex_mem_read = 1'b0;
    send(32'h007004B3, 32'h10C, 32'h0, 32'hDEAD, 32'h0, 32'hDEAD, 32'h7);

    // addi x10,x5,5 held for 3 cycles, then flushed with a concurrent input
    send(32'h00528513, 32'h110, 32'h1234, 32'h1234, 32'h1234, 32'h1234, 32'h5);
    ex_ready = 1'b0;
    instruction = 32'h123450B7; pc = 32'h114;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("hold.id_ready", {31'd0, id_ready0}, 32'd0);
      chk("hold.id_valid", {31'd0, id_valid0}, 32'd1);
      chk("hold.instruction", instr_o0, 32'h00528513);
      chk("hold.rs1_data", rs1d0, 32'h1234);
      @(posedge clk); #1;
    end
    flush = 1'b1; ex_ready = 1'b1;
    void'(q0.pop_front());
    void'(q1.pop_front());
    tick();
    flush = 1'b0; if_valid = 1'b0;
    @(negedge clk);
    chk("flush.id_valid", {31'd0, id_valid0}, 32'd0);
    @(posedge clk); #1;

    // Immediate formats, back to back
    send(32'hFE000EE3, 32'h200, 32'h0, 32'h0, 32'h0, 32'h0, 32'hFFFFFFFC);
    send(32'h0010006F, 32'h204, 32'h0, 32'h0, 32'h0, 32'h0, 32'h00000800);
    send(32'hABCDE0B7, 32'h208, 32'h0, 32'h0, 32'h0, 32'h0, 32'hABCDE000);
    send(32'hFE502C23, 32'h20C, 32'h0, 32'h1234, 32'h0, 32'h1234, 32'hFFFFFFF8);

    // Write to x0 concurrent with and before a read of x0
    wb_we = 1'b1; wb_addr = 5'd0; wb_data = 32'hFFFF;
    send(32'h00000593, 32'h300, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0);
    wb_we = 1'b0;
    send(32'h00000593, 32'h304, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0);

    // Asynchronous reset while the stage holds a valid instruction
    send(32'hFFF28313, 32'h400, 32'h1234, 32'h0, 32'h1234, 32'h0, 32'hFFFFFFFF);
    if_valid = 1'b0; ex_ready = 1'b0;
    @(negedge clk);
    chk("prereset.id_valid", {31'd0, id_valid0}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_reset.id_valid", {31'd0, id_valid0}, 32'd0);
    chk("async_reset.pc", pc_o0, 32'd0);
    chk("async_reset.rs1_data", rs1d0, 32'd0);
    void'(q0.pop_front());
    void'(q1.pop_front());
    @(posedge clk); #1;
    rst_n = 1'b1; ex_ready = 1'b1;
    send(32'hFFF28313, 32'h500, 32'h0, 32'h0, 32'h0, 32'h0, 32'hFFFFFFFF);
    if_valid = 1'b0;
    repeat (3) tick();

    chk("drain.q0_empty", q0.size(), 32'd0);
    chk("drain.q1_empty", q1.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/pipeline_decode_stage.md
Name: pipeline_decode_stage

Overview:
Parametrised successor to the combinational decode block. It contains the register file, the immediate generator and a registered ID/EX pipeline boundary. The boundary has a valid/ready handshake, a flush input, WB-to-ID write-first bypass and load-use hazard stall detection. It sits between the fetch stage and the execute stage of the 5-stage pipeline.

Parameters:
XLEN, 32, datapath and register width in bits (32 or 64)
NREGS, 32, architectural register count (32 = RV32I, 16 = RV32E); AW = $clog2(NREGS)
BYPASS_EN, 1, 1 enables WB-to-ID write-first forwarding; 0 means reads see the old value in the same cycle

Ports:
clk_i  input  1  clock, all state on the rising edge
rst_ni  input  1  asynchronous active-low reset
if_valid_i  input  1  fetch presents a valid instruction
id_ready_o  output  1  decode accepts the instruction this cycle
instruction_i  input  32  instruction word from fetch
pc_i  input  XLEN  PC of instruction_i
wb_we_i  input  1  writeback register-write enable
wb_addr_i  input  5  writeback destination register
wb_data_i  input  XLEN  writeback data
ex_ready_i  input  1  execute accepts the ID/EX contents
ex_rd_i  input  5  rd of the instruction currently in EX
ex_mem_read_i  input  1  instruction in EX is a load
flush_i  input  1  kill the ID/EX contents (branch taken or jump)
id_valid_o  output  1  ID/EX register holds a valid instruction
hazard_stall_o  output  1  load-use hazard detected this cycle
instruction_o  output  32  registered instruction
pc_o  output  XLEN  registered PC
opcode_o  output  7  registered opcode, instr[6:0]
funct3_o  output  3  registered instr[14:12]
funct7_o  output  7  registered instr[31:25]
rs1_o, rs2_o, rd_o  output  5 each  registered register addresses
rs1_data_o, rs2_data_o  output  XLEN each  registered operand data
imm_o  output  XLEN  registered sign-extended immediate

Behaviour:
- Reset (rst_ni=0, asynchronous): all register-file entries = 0; id_valid_o = 0; all registered outputs = 0. Reset mid-stall or mid-flush leaves the stage empty on release.
- Register file:
  - NREGS x XLEN entries; written on posedge when wb_we_i and wb_addr_i != 0.
  - x0 always reads 0.
  - An address >= NREGS reads 0 and the write is ignored.
- Reads are combinational from instruction_i[19:15] and [24:20].
- Bypass (BYPASS_EN=1): if wb_we_i, wb_addr_i != 0 and wb_addr_i == rsN, then rsN data = wb_data_i.
- Immediate, selected by opcode, sign-extended from instr[31] to XLEN:
  - S (0100011): {instr[31:25], instr[11:7]}
  - B (1100011): {instr[31], instr[7], instr[30:25], instr[11:8], 0}
  - U (0110111, 0010111): {instr[31:12], 12'b0}
  - J (1101111): {instr[31], instr[19:12], instr[20], instr[30:21], 0}
  - All other opcodes (I-type, load, JALR): instr[31:20]
- Hazard: hazard_stall_o = if_valid_i & ex_mem_read_i & (ex_rd_i != 0) & (ex_rd_i == rs1 | ex_rd_i == rs2). The check is combinational and compares both fields regardless of format.
- Handshake:
  - id_ready_o = (!id_valid_o | ex_ready_i) & !hazard_stall_o.
  - The ID/EX register captures the decoded fields and sets id_valid_o = 1 when if_valid_i & id_ready_o.
- Drain: if ex_ready_i and no new capture (no valid input, or a hazard), id_valid_o <= 0. This inserts a bubble; payload registers hold their last values.
- Hold: if id_valid_o & !ex_ready_i, all ID/EX registers hold and id_ready_o = 0.
- Flush has highest priority: next cycle id_valid_o = 0 and any concurrent capture is discarded. Register-file writes are unaffected.
- Simultaneous WB write and capture of the same register: the captured data is the new value with bypass, the old value without.
- Latency: 1 cycle from acceptance to id_valid_o. Throughput is 1 instruction per cycle with no stalls.

Test Plan:
1. Reset, then load x5=0x1234 via WB; addi x6,x5,-1 (0xFFF28313) -> next cycle id_valid_o=1, rs1_data_o=0x1234, imm_o=0xFFFFFFFF, rd_o=6.
2. WB write x7=0xDEAD in the same cycle as capture of add x8,x7,x0 -> rs1_data_o=0xDEAD (BYPASS_EN=1); previous value with BYPASS_EN=0.
3. ex_mem_read_i=1, ex_rd_i=7, input uses rs2=x7 -> hazard_stall_o=1, id_ready_o=0, next cycle id_valid_o=0 (bubble); on release the instruction is accepted.
4. ex_ready_i=0 for 3 cycles with id_valid_o=1 -> outputs stable, id_ready_o=0. Then flush_i=1 -> id_valid_o=0 the next cycle and the concurrent input is dropped.
5. Immediates: beq offset -4 (0xFE000EE3) -> imm_o=0xFFFFFFFC; jal +2048 (0x0010006F) -> imm_o=0x800; lui 0xABCDE (0xABCDE0B7) -> imm_o=0xABCDE000.
6. Write to x0 with 0xFFFF, then read x0 -> 0. Assert rst_ni low while id_valid_o=1 -> id_valid_o=0 immediately (asynchronous) and the register file is zeroed.
